core_stream_ctrl: RTL and testbench

//  Command-driven memory sequencer for the accelerator core, replacing hard-wired instruction-field decode.

---
 rtl/core_stream_ctrl.sv | 111 +++++++++++
 tb/tb_core_stream_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_stream_ctrl.sv
// core_stream_ctrl: command sequencer that loads XMem, feeds XMem rows to the PE array and drains PMem psums.
module core_stream_ctrl #(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int ADDR_W  = 11,
  parameter int RD_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic                     cmd_mode,
  input  logic [ADDR_W-1:0]        cmd_base,
  input  logic [ADDR_W-1:0]        cmd_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BW*ROW-1:0]        in_data,
  output logic                     xmem_cen,
  output logic                     xmem_wen,
  output logic [ADDR_W-1:0]        xmem_a,
  output logic [BW*ROW-1:0]        xmem_d,
  input  logic [BW*ROW-1:0]        xmem_q,
  output logic                     pmem_cen,
  output logic [ADDR_W-1:0]        pmem_a,
  input  logic [PSUM_BW*COL-1:0]   pmem_q,
  output logic                     arr_valid,
  output logic [BW*ROW-1:0]        arr_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PSUM_BW*COL-1:0]   out_data,
  output logic                     done,
  output logic                     err
);
  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] base, len, issued, addr;
  logic err_r, wr, xrd, prd, fire, push, pop, rej;
  logic [RD_LAT-1:0] xp, pp;
  logic [PSUM_BW*COL-1:0] fifo [8];
  logic [2:0] wp, rp, cnt, infl;
  assign addr = base + issued;
  assign rej = cmd_op == 2'b11 || (cmd_op == 2'b10 && !cmd_mode);
  assign wr = state == LOAD && in_valid;
  assign xrd = state == FEED;
  assign pop = out_valid && out_ready;
  assign push = pp[RD_LAT-1];
  // A PMem read takes a credit only if its word is guaranteed a FIFO slot, counting this cycle's pop.
  assign prd = state == DRAIN && (infl + cnt - 3'(pop)) < 3'(RD_LAT + 1);
  assign fire = wr || xrd || prd;
  assign cmd_ready = state == IDLE;
  assign in_ready = state == LOAD;
  assign xmem_cen = !(wr || xrd);
  assign xmem_wen = !wr;
  assign xmem_a = (wr || xrd) ? addr : '0;
  assign xmem_d = wr ? in_data : '0;
  assign pmem_cen = !prd;
  assign pmem_a = prd ? addr : '0;
  assign arr_valid = xp[RD_LAT-1];
  assign arr_data = arr_valid ? xmem_q : '0;
  assign out_valid = cnt != 3'd0;
  assign out_data = out_valid ? fifo[rp] : '0;
  assign done = state == DONE;
  assign err = done && err_r;
  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) infl = infl + 3'(pp[i]);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:              if (cmd_valid) state_n = (rej || cmd_len == '0) ? DONE :
                                                  cmd_op == 2'b00 ? LOAD : cmd_op == 2'b01 ? FEED : DRAIN;
      LOAD, FEED, DRAIN: if (fire && issued + ADDR_W'(1) == len) state_n = FLUSH;
      FLUSH:             if (xp == '0 && pp == '0 && cnt == 3'd0) state_n = DONE;
      default:           state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      base <= '0;
      len <= '0;
      issued <= '0;
      err_r <= 1'b0;
      xp <= '0;
      pp <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid) begin
        base <= cmd_base;
        len <= cmd_len;
        issued <= '0;
        err_r <= rej;
      end else if (fire) issued <= issued + ADDR_W'(1);
      xp <= RD_LAT'({xp, xrd});
      pp <= RD_LAT'({pp, prd});
      if (push) begin
        fifo[wp] <= pmem_q;
        wp <= wp == 3'(RD_LAT) ? 3'd0 : wp + 3'd1;
      end
      if (pop) rp <= rp == 3'(RD_LAT) ? 3'd0 : rp + 3'd1;
      cnt <= cnt + 3'(push) - 3'(pop);
    end
  end
endmodule

// File: tb/tb_core_stream_ctrl.sv
// tb_core_stream_ctrl: randomized scoreboard bench with SRAM models and a transaction-level reference.
module tb_core_stream_ctrl;
  localparam int RD_LAT = 2;
  localparam int N = 2048;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready, cmd_mode = 0, in_valid = 0, in_ready, out_ready = 0;
  logic [1:0] cmd_op = 0;
  logic [10:0] cmd_base = 0, cmd_len = 0, xmem_a, pmem_a;
  logic [31:0] in_data = 0, xmem_d, xmem_q, arr_data;
  logic [127:0] pmem_q, out_data;
  logic xmem_cen, xmem_wen, pmem_cen, arr_valid, out_valid, done, err;
  always #5 clk = ~clk;

  core_stream_ctrl #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_mode(cmd_mode), .cmd_base(cmd_base), .cmd_len(cmd_len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .xmem_cen(xmem_cen), .xmem_wen(xmem_wen),
    .xmem_a(xmem_a), .xmem_d(xmem_d), .xmem_q(xmem_q), .pmem_cen(pmem_cen), .pmem_a(pmem_a),
    .pmem_q(pmem_q), .arr_valid(arr_valid), .arr_data(arr_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .done(done), .err(err));

  bit [31:0] xmem [N];
  bit [31:0] ref_x [N];
  logic [127:0] pmem [N];
  logic [31:0] xq [RD_LAT];
  logic [127:0] pq [RD_LAT];
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!xmem_cen && !xmem_wen) xmem[xmem_a] <= xmem_d;
    xq[0] <= xmem[xmem_a];
    pq[0] <= pmem[pmem_a];
    for (int k = 1; k < RD_LAT; k++) begin
      xq[k] <= xq[k-1];
      pq[k] <= pq[k-1];
    end
  end
  assign xmem_q = xq[RD_LAT-1];
  assign pmem_q = pq[RD_LAT-1];

  typedef struct {logic [10:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic e; int at;} dn_t;
  wr_t exp_wr[$];
  logic [10:0] exp_rd[$];
  logic [31:0] exp_arr[$];
  logic [127:0] exp_out[$];
  int rd_cyc[$];
  dn_t exp_dn[$];
  int total = 0, bad = 0, done_cnt = 0, pops = 0, beats = 0, first_b = 0, last_b = 0;
  logic hold_v = 0;
  logic [127:0] hold_d = 0;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (reset) hold_v = 0;
    else begin
      if (hold_v) begin
        chk("out_hold_valid", 128'(out_valid), 128'(1));
        chk("out_hold_data", out_data, hold_d);
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      if (!xmem_cen && !xmem_wen) begin
        chk("xwr_expected", 128'(exp_wr.size() != 0), 128'(1));
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          chk("xwr_addr", 128'(xmem_a), 128'(w.a));
          chk("xwr_data", 128'(xmem_d), 128'(w.d));
        end
      end
      if (!xmem_cen && xmem_wen || !pmem_cen) begin
        chk("rd_expected", 128'(exp_rd.size() != 0), 128'(1));
        if (exp_rd.size() != 0) chk("rd_addr", 128'(xmem_cen ? pmem_a : xmem_a), 128'(exp_rd.pop_front()));
        if (!xmem_cen) rd_cyc.push_back(cyc);
      end
      if (arr_valid) begin
        chk("arr_expected", 128'(exp_arr.size() != 0 && rd_cyc.size() != 0), 128'(1));
        if (exp_arr.size() != 0 && rd_cyc.size() != 0) begin
          chk("arr_data", 128'(arr_data), 128'(exp_arr.pop_front()));
          chk("arr_lag", 128'(cyc - rd_cyc.pop_front()), 128'(RD_LAT));
        end
      end
      if (out_valid && out_ready) begin
        chk("out_expected", 128'(exp_out.size() != 0), 128'(1));
        if (exp_out.size() != 0) chk("out_data", out_data, exp_out.pop_front());
        if (beats == 0) first_b = cyc;
        last_b = cyc;
        beats++;
        pops++;
      end
      if (done) begin
        done_cnt++;
        chk("done_expected", 128'(exp_dn.size() != 0), 128'(1));
        if (exp_dn.size() != 0) begin
          d = exp_dn.pop_front();
          chk("err", 128'(err), 128'(d.e));
          if (d.at >= 0) chk("done_cycle", 128'(cyc), 128'(d.at));
        end
        chk("drained", 128'(exp_wr.size() + exp_rd.size() + exp_arr.size() + exp_out.size()), 128'(0));
      end else if (err) chk("err_without_done", 128'(err), 128'(0));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle;
    chk("idle_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("idle_in_ready", 128'(in_ready), 128'(0));
    chk("idle_arr_valid", 128'(arr_valid), 128'(0));
    chk("idle_out_valid", 128'(out_valid), 128'(0));
    chk("idle_done_err", 128'({done, err}), 128'(0));
    chk("idle_cen_wen", 128'({xmem_cen, xmem_wen, pmem_cen}), 128'(3'b111));
    chk("idle_addr", 128'({xmem_a, pmem_a}), 128'(0));
    chk("idle_data", {xmem_d, arr_data, out_data[63:0]}, 128'(0));
  endtask

  task automatic flush_all;
    exp_wr.delete(); exp_rd.delete(); exp_arr.delete(); exp_out.delete(); rd_cyc.delete(); exp_dn.delete();
  endtask

  task automatic issue(input logic [1:0] op, input logic mode, input logic [10:0] base, input logic [10:0] len);
    chk("cmd_ready_before_issue", 128'(cmd_ready), 128'(1));
    beats = 0;
    cmd_valid = 1; cmd_op = op; cmd_mode = mode; cmd_base = base; cmd_len = len;
    tick;
    cmd_valid = 0; cmd_op = 0; cmd_mode = 0; cmd_base = 0; cmd_len = 0;
  endtask

  task automatic wait_done(input int orm);
    int s = done_cnt;
    logic [3:0] pat = 4'b1001;
    for (int k = 0; k < 400 && done_cnt == s; k++) begin
      out_ready = orm == 0 ? 1'b1 : orm == 1 ? pat[k%4] : 1'($urandom);
      tick;
    end
    out_ready = 0;
    chk("done_timeout", 128'(done_cnt != s), 128'(1));
  endtask

  // inv: 0 = in_valid always, 1 = pattern 1,0,1,1, 2 = random; orm: 0 = ready, 1 = 1,0,0,1, 2 = random
  task automatic run(input logic [1:0] op, input logic mode, input logic [10:0] base, input logic [10:0] len,
                     input int inv, input int orm);
    logic rj = op == 2'b11 || (op == 2'b10 && !mode);
    logic [10:0] a;
    logic [3:0] gp = 4'b1101;
    int last = 0;
    if (rj || len == 0) exp_dn.push_back('{rj, cyc + 1});
    else if (op != 2'b00) begin
      for (int i = 0; i < int'(len); i++) begin
        a = base + 11'(i);
        exp_rd.push_back(a);
        if (op == 2'b01) exp_arr.push_back(ref_x[a]);
        else exp_out.push_back(pmem[a]);
      end
      exp_dn.push_back('{1'b0, -1});
    end
    issue(op, mode, base, len);
    if (op == 2'b00 && !rj && len != 0) begin
      for (int i = 0, k = 0; i < int'(len); k++) begin
        in_valid = inv == 0 ? 1'b1 : inv == 1 ? gp[k%4] : 1'($urandom);
        if (in_valid) begin
          in_data = $urandom;
          a = base + 11'(i);
          exp_wr.push_back('{a, in_data});
          ref_x[a] = in_data;
          last = cyc;
          i++;
        end
        tick;
      end
      in_valid = 0;
      exp_dn.push_back('{1'b0, last + 2});
    end
    wait_done(orm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    for (int i = 0; i < N; i++) pmem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) tick;
    check_idle;
    reset = 0;
    tick;
    check_idle;
    run(2'b00, 0, 11'd5, 11'd3, 1, 0);
    run(2'b00, 0, 11'd2046, 11'd4, 0, 0);
    run(2'b01, 1, 11'd2046, 11'd4, 0, 0);
    run(2'b10, 1, 11'd0, 11'd8, 0, 0);
    chk("drain_throughput", 128'(last_b - first_b), 128'(7));
    run(2'b10, 1, 11'd0, 11'd8, 0, 1);
    run(2'b10, 0, 11'd0, 11'd8, 0, 0);
    run(2'b11, 1, 11'd0, 11'd8, 0, 0);
    run(2'b01, 0, 11'd0, 11'd0, 0, 0);
    for (int i = 0; i < 10; i++) exp_out.push_back(pmem[100 + i]);
    for (int i = 0; i < 10; i++) exp_rd.push_back(11'(100 + i));
    exp_dn.push_back('{1'b0, -1});
    p0 = pops;
    issue(2'b10, 1, 11'd100, 11'd10);
    for (int k = 0; k < 100 && pops - p0 < 4; k++) begin
      out_ready = 1;
      tick;
    end
    chk("mid_drain_pops", 128'(pops - p0), 128'(4));
    reset = 1;
    out_ready = 0;
    flush_all;
    tick;
    reset = 0;
    check_idle;
    run(2'b10, 1, 11'd0, 11'd8, 0, 2);
    for (int i = 0; i < 14; i++)
      run(2'($urandom), 1'($urandom_range(0, 3) != 0), 11'($urandom), 11'($urandom_range(0, 12)), 2, 2);
    run(2'b01, 0, 11'd5, 11'd3, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
